demux_1_para_8_5bits_reg: RTL



---
 rtl/demux_1_para_8_5bits_reg_pkg.sv | 13 +
 rtl/slot_reg_5bits.sv | 28 ++
 rtl/demux_1_para_8_5bits_reg.sv | 84 ++++++++
 3 files changed

// File: rtl/demux_1_para_8_5bits_reg_pkg.sv
// Shared sizing constants and slot bit-position helper for the 1-to-8 result distributor.
package demux_1_para_8_5bits_reg_pkg;

  localparam int unsigned SLOT_W  = 5;
  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned SEL_W   = 3;

  // Lowest bit of slot k inside the packed out_data bus.
  function automatic int unsigned slot_lsb(input int unsigned k);
    return SLOT_W * k;
  endfunction

endpackage

// File: rtl/slot_reg_5bits.sv
// One holding slot: a data register plus a valid flag. A write in the same cycle as an ack
// wins, so the slot stays valid and takes the new data.
module slot_reg_5bits
  import demux_1_para_8_5bits_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_data,
  input  logic              ack,
  output logic [SLOT_W-1:0] data,
  output logic              valid
);

  // Slot state: reset clears, write loads and sets valid, ack alone only drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_para_8_5bits_reg.sv
// Registered 1-to-8 distributor for 5-bit results. Each accepted word lands in the slot named
// by in_sel or by the auto-increment pointer; each slot is freed by its own consumer ack.
module demux_1_para_8_5bits_reg
  import demux_1_para_8_5bits_reg_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLOT_W-1:0]          in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       auto_inc,
  output logic [N_SLOTS*SLOT_W-1:0]  out_data,
  output logic [N_SLOTS-1:0]         out_valid,
  input  logic [N_SLOTS-1:0]         out_ack,
  output logic [SEL_W-1:0]           wr_ptr,
  output logic [SEL_W:0]             occ_count
);

  localparam logic [SEL_W:0] OccOne = 1;

  logic [SEL_W-1:0]   tgt;
  logic               wr_fire;
  logic [N_SLOTS-1:0] wr_en;
  logic [SEL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SEL_W:0]     occ_q, occ_d;

  assign tgt = auto_inc ? wr_ptr_q : in_sel;
  // A full target can still accept when its consumer drains it in the same cycle.
  assign in_ready = ~rst & (~out_valid[tgt] | out_ack[tgt]);
  assign wr_fire  = in_valid & in_ready;

  // 3-to-8 write decode of the target slot.
  always_comb begin
    wr_en = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      wr_en[k] = wr_fire && (tgt == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : gen_slot
    slot_reg_5bits u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_data (in_data),
      .ack     (out_ack[g]),
      .data    (out_data[slot_lsb(g) +: SLOT_W]),
      .valid   (out_valid[g])
    );
  end

  // Next pointer and occupancy; acks overlapped by a same-slot write do not count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (wr_fire && auto_inc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (wr_fire && !out_valid[tgt]) begin
      occ_d = occ_d + OccOne;
    end
    for (int k = 0; k < N_SLOTS; k++) begin
      if (out_ack[k] && out_valid[k] && !wr_en[k]) begin
        occ_d = occ_d - OccOne;
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign occ_count = occ_q;

endmodule
